kuznechik_inv_l: RTL and testbench

KUZNECHIK_INV_L -- requirements
Module: kuznechik_inv_l

---
 rtl/kuznechik_inv_l.sv | 119 +++++++++++
 tb/tb_kuznechik_inv_l.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_inv_l.sv
// kuznechik_inv_l: iterative inverse of the Kuznechik linear layer L (16 x R^-1).
// Define KUZ_INV_L_DUAL_ROUND_EN to chain two R^-1 per cycle (8-cycle RUN phase).
module kuznechik_inv_l (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef KUZ_INV_L_DUAL_ROUND_EN
  localparam logic [3:0] LAST_CNT = 4'd7;
`else
  localparam logic [3:0] LAST_CNT = 4'd15;
`endif

  // c_0..c_14; c_15 is 1, so the last byte is recovered by a plain XOR
  localparam logic [7:0] COEF [15] = '{
    8'h94, 8'h20, 8'h85, 8'h10, 8'hC2, 8'hC0, 8'h01, 8'hFB,
    8'h01, 8'hC0, 8'hC2, 8'h10, 8'h85, 8'h20, 8'h94
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] r_inv(input logic [127:0] b);
    logic [7:0] t;
    t = b[7:0];
    for (int i = 0; i < 15; i++) t = t ^ gf_mul(COEF[i], b[8*i+8 +: 8]);
    return {t, b[127:8]};
  endfunction

  logic [1:0]   fsm_reg, fsm_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] round1, round_next;
  logic         load;

  assign round1 = r_inv(state_reg);
`ifdef KUZ_INV_L_DUAL_ROUND_EN
  assign round_next = r_inv(round1);
`else
  assign round_next = round1;
`endif

  assign in_ready  = (fsm_reg == IDLE) || ((fsm_reg == DONE) && out_ready);
  assign out_valid = (fsm_reg == DONE);
  assign busy      = (fsm_reg == RUN);
  assign out_data  = state_reg;
  assign load      = in_valid && in_ready;

  always_comb begin
    fsm_next   = fsm_reg;
    cnt_next   = cnt_reg;
    state_next = state_reg;
    case (fsm_reg)
      IDLE: begin
        if (load) begin
          state_next = in_data;
          cnt_next   = 4'd0;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        state_next = round_next;
        if (cnt_reg == LAST_CNT) begin
          cnt_next = 4'd0;
          fsm_next = DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        // retiring the result and accepting the next block share one edge
        if (load) begin
          state_next = in_data;
          cnt_next   = 4'd0;
          fsm_next   = RUN;
        end else if (out_ready) begin
          fsm_next = IDLE;
        end
      end
      default: begin
        fsm_next = IDLE;
        cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      cnt_reg   <= 4'd0;
      state_reg <= 128'd0;
    end else begin
      fsm_reg   <= fsm_next;
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
    end
  end

endmodule

// File: tb/tb_kuznechik_inv_l.sv
// Self-checking bench for kuznechik_inv_l: results are verified by re-applying a forward-L model.
module tb_kuznechik_inv_l;

`ifdef KUZ_INV_L_DUAL_ROUND_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;

  logic [127:0] exp_q[$];
  int           load_q[$];
  logic         valid_seen = 1'b0;

  kuznechik_inv_l dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // carry-less product followed by polynomial reduction mod x^8+x^7+x^6+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h1C3 << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] fwd_r(input logic [127:0] a);
    logic [7:0] c [16];
    logic [7:0] x;
    c = '{8'h94, 8'h20, 8'h85, 8'h10, 8'hC2, 8'hC0, 8'h01, 8'hFB,
          8'h01, 8'hC0, 8'hC2, 8'h10, 8'h85, 8'h20, 8'h94, 8'h01};
    x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ gmul(c[i], a[8*i +: 8]);
    return {a[119:0], x};
  endfunction

  function automatic logic [127:0] fwd_l(input logic [127:0] a);
    logic [127:0] s;
    s = a;
    for (int r = 0; r < 16; r++) s = fwd_r(s);
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Compare process: latency on each out_valid rise, result on each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      load_q.delete();
      valid_seen = 1'b0;
    end else begin
      if (out_valid && !valid_seen) begin
        valid_seen = 1'b1;
        n_cmp++;
        if (load_q.size() == 0) begin
          n_err++;
          $display("FAIL latency: out_valid with no block pending, cycle %0d", cyc);
        end else if (cyc - load_q[0] != LAT) begin
          n_err++;
          $display("FAIL latency: got %0d cycles expected %0d", cyc - load_q[0], LAT);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL result: unexpected output %h", out_data);
        end else begin
          if (fwd_l(out_data) !== exp_q[0]) begin
            n_err++;
            $display("FAIL result: L(out)=%h expected %h", fwd_l(out_data), exp_q[0]);
          end
          void'(exp_q.pop_front());
          void'(load_q.pop_front());
        end
        valid_seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        load_q.push_back(cyc + 1);
        n_in++;
      end
    end
  end

  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    n_cmp++;
    if (!in_ready) begin n_err++; $display("FAIL send_timeout: in_ready got 0 required 1"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic [127:0] r);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    n_cmp++;
    if (!out_valid) begin n_err++; $display("FAIL valid_timeout: out_valid got 0 required 1"); end
    r = out_data;
    @(posedge clk); #1;
  endtask

  logic [127:0] r0, r1, r2, r3, hold_v;
  int in0, out0, guard, sent;

  initial begin
    // model pins, computed by hand
    chk("pin_gmul_80x02", 128'(gmul(8'h80, 8'h02)), 128'hC3);
    chk("pin_r_byte0", fwd_r(128'h1), 128'h194);
    chk("pin_r_byte15", fwd_r(128'h1 << 120), 128'h1);
    chk("pin_r_byte1", fwd_r(128'h200), 128'h20040);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'h1);
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    send(128'h0);
    wait_valid(r0);
    chk("zero_block", r0, 128'h0);

    send(128'h00112233445566778899AABBCCDDEEFF);
    wait_valid(r0);
    chk("golden_vector", fwd_l(r0), 128'h00112233445566778899AABBCCDDEEFF);

    send(128'h1);   wait_valid(r1);
    send(128'h100); wait_valid(r2);
    send(128'h101); wait_valid(r3);
    chk("linearity", r3, r1 ^ r2);

    // DONE hold with out_ready low, then back-to-back release
    out_ready = 1'b0;
    send(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    wait_valid(hold_v);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid), 128'h1);
      chk("hold_out_data", out_data, hold_v);
      chk("hold_in_ready", 128'(in_ready), 128'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 128'hFFEEDDCCBBAA99887766554433221100;
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready), 128'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_busy", 128'(busy), 128'h1);
    chk("b2b_out_valid", 128'(out_valid), 128'h0);
    wait_valid(r0);
    chk("b2b_result", fwd_l(r0), 128'hFFEEDDCCBBAA99887766554433221100);

    // reset in the middle of RUN
    send(128'h0123456789ABCDEF0123456789ABCDEF);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'h0);
    chk("midrst_in_ready", 128'(in_ready), 128'h1);
    chk("midrst_out_data", out_data, 128'h0);
    chk("midrst_busy", 128'(busy), 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(128'h13579BDF2468ACE013579BDF2468ACE0);
    wait_valid(r0);
    chk("post_rst_result", fwd_l(r0), 128'h13579BDF2468ACE013579BDF2468ACE0);

    // random traffic
    in0 = n_in;
    out0 = n_out;
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 1) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("random_sent", 128'(sent), 128'd1000);
    chk("random_in_count", 128'(n_in - in0), 128'd1000);
    chk("random_out_count", 128'(n_out - out0), 128'(n_in - in0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
